// File: rtl/frq_divider_pkg.sv
// Shared constants for the frequency divider bank: divisor ROM, channel FSM states and
// default widths.
package frq_divider_pkg;

  localparam int unsigned DefNCh  = 4;
  localparam int unsigned DefSelW = 5;
  localparam int unsigned DefCntW = 16;
  localparam int unsigned DivW    = 9;

  localparam logic [1:0] StOff = 2'd0;
  localparam logic [1:0] StHi  = 2'd1;
  localparam logic [1:0] StLo  = 2'd2;

  // Code 0 is off, 1..15 give k+1, 16..31 give (k-14)*16.
  localparam logic [DivW-1:0] FRQ_ROM [32] = '{
    9'd0,   9'd2,   9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,
    9'd9,   9'd10,  9'd11,  9'd12,  9'd13,  9'd14,  9'd15,  9'd16,
    9'd32,  9'd48,  9'd64,  9'd80,  9'd96,  9'd112, 9'd128, 9'd144,
    9'd160, 9'd176, 9'd192, 9'd208, 9'd224, 9'd240, 9'd256, 9'd272
  };

endpackage

// File: rtl/frq_div_channel.sv
// One divider channel: OFF/HI/LO FSM with a pending code applied at the period boundary.
// Optional phase-alignment input when FRQ_DIV_SYNC_EN is defined.
module frq_div_channel
  import frq_divider_pkg::*;
#(
  parameter int unsigned SEL_W = DefSelW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             we,
`ifdef FRQ_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             pend
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       act_q, act_d;
  logic [4:0]       pcode_q, pcode_d;
  logic             pend_q, pend_d;
  logic             clk_out_q;

  logic [4:0]       sel_code, new_code;
  logic [DivW-1:0]  new_div;
  logic             boundary, align, apply;

  // Codes beyond the ROM range behave as "off".
  function automatic logic [4:0] norm_code(input logic [SEL_W-1:0] s);
    if (32'(s) > 32'd31) return 5'd0;
    return 5'(s);
  endfunction

  function automatic logic [CNT_W-1:0] hi_cnt(input logic [DivW-1:0] d);
    return CNT_W'({1'b0, d[DivW-1:1]} - 9'd1);
  endfunction

  function automatic logic [CNT_W-1:0] lo_cnt(input logic [DivW-1:0] d);
    return CNT_W'(d - {1'b0, d[DivW-1:1]} - 9'd1);
  endfunction

  assign sel_code = norm_code(sel);
  assign boundary = (state_q == StLo) && (cnt_q == '0);
  // A write in the same cycle wins over an older pending code.
  assign new_code = we ? sel_code : (pend_q ? pcode_q : act_q);
  assign new_div  = FRQ_ROM[new_code];

`ifdef FRQ_DIV_SYNC_EN
  assign align = sync && (state_q != StOff);
`else
  assign align = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pcode_d = pcode_q;
    pend_d  = pend_q;
    apply   = 1'b0;

    if (state_q == StOff) begin
      apply = we;
    end else if (boundary || align) begin
      apply = 1'b1;
    end else begin
      if (we) begin
        pcode_d = sel_code;
        pend_d  = 1'b1;
      end
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = StLo;
        cnt_d   = lo_cnt(FRQ_ROM[act_q]);
      end
    end

    if (apply) begin
      act_d  = new_code;
      pend_d = 1'b0;
      if (new_div == '0) begin
        state_d = StOff;
        cnt_d   = '0;
      end else begin
        state_d = StHi;
        cnt_d   = hi_cnt(new_div);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      act_q     <= '0;
      pcode_q   <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      pcode_q   <= pcode_d;
      pend_q    <= pend_d;
      clk_out_q <= (state_d == StHi);
    end
  end

  assign clk_out = clk_out_q;
  assign pend    = pend_q;

endmodule

// File: rtl/frq_divider_bank.sv
// Bank of N_CH independent programmable clock dividers.
// Defining FRQ_DIV_SYNC_EN adds a sync input that phase-aligns all running channels.
module frq_divider_bank
  import frq_divider_pkg::*;
#(
  parameter int unsigned N_CH  = DefNCh,
  parameter int unsigned SEL_W = DefSelW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH*SEL_W-1:0] sel_in,
  input  logic [N_CH-1:0]       sel_we,
`ifdef FRQ_DIV_SYNC_EN
  input  logic                  sync,
`endif
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       pend
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    frq_div_channel #(
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .sel     (sel_in[c*SEL_W +: SEL_W]),
      .we      (sel_we[c]),
`ifdef FRQ_DIV_SYNC_EN
      .sync    (sync),
`endif
      .clk_out (clk_out[c]),
      .pend    (pend[c])
    );
  end

endmodule

// File: doc/frq_divider_bank.md
FRQ_DIVIDER_BANK -- requirements
Module: frq_divider_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent divider channels (1..8).
REQ-002 SHALL have parameter SEL_W, default 5, width of each channel's ROM select code.
REQ-003 SHALL have parameter CNT_W, default 16, width of each channel's period counter; must be at least 9 for the default ROM.
REQ-004 SHALL have port clk, input, 1, the single clock for all state.
REQ-005 SHALL have port reset_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port sel_in, input, N_CH*SEL_W, select codes, channel c at bits [c*SEL_W +: SEL_W].
REQ-007 SHALL have port sel_we, input, N_CH, per-channel one-cycle write strobe for sel_in.
REQ-008 SHALL have port clk_out, output, N_CH, divided clock per channel, registered.
REQ-009 SHALL have port pend, output, N_CH, high while a written code awaits its period boundary.

Function
REQ-010 SHALL look up divisor D = FRQ_ROM[code]: code 0 gives D=0 (channel off); k=1..15 gives D=k+1; k=16..31 gives D=(k-14)*16 (32..272).
REQ-011 SHALL run each channel as FSM OFF -> HI -> LO -> HI ...; clk_out=1 only in HI.
REQ-012 SHALL hold HI for floor(D/2) cycles and LO for D-floor(D/2) cycles, giving period exactly D cycles.
REQ-013 SHALL, on sel_we[c]=1, capture the code into a pending register and set pend[c] on the next edge.
REQ-014 SHALL apply the pending code only at the last LO cycle of a period (the boundary), then clear pend; no runt high or low pulses.
REQ-015 SHALL, if sel_we coincides with the boundary cycle, apply the newly written code at that boundary (write-through).
REQ-016 SHALL, in OFF, apply a write on the next edge: nonzero code enters HI with a fresh count; pend never asserts.
REQ-017 SHALL enter OFF at the boundary when code 0 is applied; clk_out stays 0.
REQ-018 SHALL keep only the last write when several writes occur before a boundary.
REQ-019 SHALL keep channels fully independent; simultaneous writes to several channels are legal.
REQ-020 SHALL treat out-of-range SEL_W codes (SEL_W>5, code>31) as code 0.
REQ-021 SHALL count down from the phase length minus 1 to 0; the counter never wraps.

Reset
REQ-022 SHALL, while reset_n=0 at a clk edge, set every channel to OFF with counter=0, active code=0, pending=0; clk_out=0 and pend=0 from that edge.
REQ-023 SHALL let reset mid-period abort the period immediately; sel_we is ignored during reset.

Configuration
REQ-024 SHALL, with FRQ_DIV_SYNC_EN defined, add input sync (1 bit); sync=1 forces every non-OFF channel to HI with a fresh count on the next edge, phase-aligning all channels; a pending code is applied at that same edge.
REQ-025 SHALL, without FRQ_DIV_SYNC_EN, have no sync port and no alignment logic.

Structure
REQ-026 SHALL put FRQ_ROM, the FSM state enum (OFF/HI/LO) and the default-width constants in package frq_divider_pkg.
REQ-027 SHALL implement one channel as sub-module frq_div_channel, instantiated N_CH times via generate.

Verification
REQ-028 SHALL test: reset, write ch0 code 3 (D=4) -> clk_out[0] gives 2 high / 2 low, period 4, pend[0] stays 0.
REQ-029 SHALL test: ch1 running code 2 (D=3), write code 16 (D=32) mid-HI -> pend[1]=1 until the boundary; the old period completes 1 high / 2 low, then 16 high / 16 low.
REQ-030 SHALL test: write on the exact boundary cycle -> the new divisor is used for the very next period.
REQ-031 SHALL test: running ch2 code 31 (D=272), write code 0 -> the current period completes, then clk_out[2]=0 held and FSM in OFF.
REQ-032 SHALL test: reset_n=0 for 1 cycle mid-HI on all channels -> all clk_out=0 and pend=0 next cycle; outputs stay 0 until a new write.
REQ-033 SHALL test, with FRQ_DIV_SYNC_EN: ch0 D=4 and ch1 D=8 at arbitrary phases, pulse sync -> both rising edges on the next cycle, then every 8 cycles coincident.
